// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide sequencer.
//   state_e                 - sequencer FSM states
//   OP_MULT / OP_DIV        - encoding of the op input
//   TIMEOUT_CYCLES_DEFAULT  - default watchdog limit in WAIT states
package muldiv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMStart,
        StMWait,
        StDStart,
        StDWait,
        StDone,
        StExc
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog: cycle counter that flags when a WAIT state has lasted too long.
// Ports:
//   clk, rst  - clock, synchronous active-low reset
//   clear     - hold the count at zero (asserted outside the WAIT states)
//   enable    - count this cycle
//   expired   - count has reached TIMEOUT_CYCLES-1 while enabled
module muldiv_watchdog
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CntW'(1);
        end
    end

    assign expired = enable && (count_q == LastCnt);

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences MULT/DIV requests to the multiply and divide units and owns HI/LO.
// Optional build macro MULDIV_TIMEOUT_EN adds a watchdog that aborts a WAIT state after
// TIMEOUT_CYCLES cycles with timeout_exc; without it WAIT states never time out.
// Ports:
//   clk, rst                       - clock, synchronous active-low reset
//   req, op, flush                 - request (op 0=MULT, 1=DIV), abort of current operation
//   hi_we, lo_we, wdata            - MTHI/MTLO writes, honoured only in IDLE
//   mult_start, mult_end, mult_*   - multiplier handshake and result
//   div_start, div_end, div_*      - divider handshake, result and zero-divisor flag
//   hi, lo                         - architectural HI/LO registers
//   busy, done, div_zero_exc, timeout_exc - status and one-cycle event pulses
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        op,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        mult_start,
    input  logic        mult_end,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        div_start,
    input  logic        div_end,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic        timeout_exc
);

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    // Cause of the pending EXC state: 1 = watchdog, 0 = divide by zero.
    logic        exc_to_q, exc_to_d;
    logic        wd_expired;

`ifdef MULDIV_TIMEOUT_EN
    logic in_wait;
    assign in_wait = (state_q == StMWait) || (state_q == StDWait);

    muldiv_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_wait),
        .enable (in_wait),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            lo_q     <= '0;
            exc_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            exc_to_q <= exc_to_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        exc_to_d     = exc_to_q;
        mult_start   = 1'b0;
        div_start    = 1'b0;
        done         = 1'b0;
        div_zero_exc = 1'b0;
        timeout_exc  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (req && !flush) begin
                    unique case (op)
                        OP_MULT: state_d = StMStart;
                        OP_DIV:  state_d = StDStart;
                    endcase
                end
            end
            StMStart: begin
                mult_start = 1'b1;
                state_d    = StMWait;
            end
            StMWait: begin
                // An end in the expiry cycle still commits.
                if (mult_end) begin
                    hi_d    = mult_hi;
                    lo_d    = mult_lo;
                    state_d = StDone;
                end else if (wd_expired) begin
                    exc_to_d = 1'b1;
                    state_d  = StExc;
                end
            end
            StDStart: begin
                div_start = 1'b1;
                state_d   = StDWait;
            end
            StDWait: begin
                if (div_by_zero) begin
                    exc_to_d = 1'b0;
                    state_d  = StExc;
                end else if (div_end) begin
                    hi_d    = div_hi;
                    lo_d    = div_lo;
                    state_d = StDone;
                end else if (wd_expired) begin
                    exc_to_d = 1'b1;
                    state_d  = StExc;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            StExc: begin
`ifdef MULDIV_TIMEOUT_EN
                timeout_exc  = exc_to_q;
`endif
                div_zero_exc = !exc_to_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush outside IDLE abandons the operation silently.
        if (flush && (state_q != StIdle)) begin
            state_d      = StIdle;
            hi_d         = hi_q;
            lo_d         = lo_q;
            mult_start   = 1'b0;
            div_start    = 1'b0;
            done         = 1'b0;
            div_zero_exc = 1'b0;
            timeout_exc  = 1'b0;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the driver plays the multiply/divide units, predicts each
// HI/LO outcome from the architectural rules and queues it; a monitor pops on every pulse.
module tb_muldiv_ctrl;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, op = 1'b0, flush = 1'b0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        mult_start, mult_end = 1'b0;
    logic [31:0] mult_hi = '0, mult_lo = '0;
    logic        div_start, div_end = 1'b0, div_by_zero = 1'b0;
    logic [31:0] div_hi = '0, div_lo = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero_exc, timeout_exc;

    muldiv_ctrl #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .op          (op),
        .flush       (flush),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .mult_start  (mult_start),
        .mult_end    (mult_end),
        .mult_hi     (mult_hi),
        .mult_lo     (mult_lo),
        .div_start   (div_start),
        .div_end     (div_end),
        .div_hi      (div_hi),
        .div_lo      (div_lo),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_zero_exc(div_zero_exc),
        .timeout_exc (timeout_exc)
    );

    always #5 clk = ~clk;

    // kind: 0 = done, 1 = divide-by-zero, 2 = timeout, 3 = several pulses at once
    typedef struct {
        int          kind;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: every result/exception pulse must match the oldest prediction.
    always @(negedge clk) begin
        int   kind;
        exp_t e;
        if (rst === 1'b1 && (done | div_zero_exc | timeout_exc) === 1'b1) begin
            if (int'(done) + int'(div_zero_exc) + int'(timeout_exc) > 1) kind = 3;
            else if (done) kind = 0;
            else if (div_zero_exc) kind = 1;
            else kind = 2;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got kind %0d want no pulse (t=%0t)", kind, $time);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", kind, e.kind);
                chk("pulse_hi", hi, e.hi);
                chk("pulse_lo", lo, e.lo);
            end
        end
    end

    task automatic clear_in();
        req = 1'b0; hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
        mult_end = 1'b0; div_end = 1'b0; div_by_zero = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: busy got 1 want 0 after %0d cycles", budget);
    endtask

    // One MULT/DIV transaction; delay = WAIT cycles before the end handshake.
    task automatic do_op(input logic o, input int delay, input bit zero, input bit fl,
                         input bit spur, input bit whi, input bit wlo,
                         input logic [31:0] rh, input logic [31:0] rl);
        logic [31:0] wd;
        wait_idle(40);
        wd = $urandom;
        req = 1'b1; op = o; hi_we = whi; lo_we = wlo; wdata = wd;
        if (whi) m_hi = wd;
        if (wlo) m_lo = wd;
        @(negedge clk);  // start cycle
        clear_in();
        chk("start_pulse", o ? div_start : mult_start, 1);
        chk("start_other", o ? mult_start : div_start, 0);
        chk("busy_start", busy, 1);
        chk("write_with_req_hi", hi, m_hi);
        @(negedge clk);  // first WAIT cycle
        chk("start_single", mult_start | div_start, 0);
        for (int i = 0; i < delay; i++) begin
            if (spur) begin
                req = 1'b1; op = 1'($urandom); hi_we = 1'b1; wdata = $urandom;
                if (o) begin
                    mult_end = 1'b1; mult_hi = $urandom; mult_lo = $urandom;
                end else begin
                    div_end = 1'b1; div_by_zero = 1'b1; div_hi = $urandom;
                end
            end
            @(negedge clk);
            chk("busy_wait", busy, 1);
        end
        clear_in();
        if (fl) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk("flush_idle", busy, 0);
            // Late handshake after the flush must be ignored.
            if (o) begin div_end = 1'b1; div_by_zero = 1'($urandom); end
            else mult_end = 1'b1;
            @(negedge clk);
            clear_in();
            chk("flush_hi", hi, m_hi);
            chk("flush_lo", lo, m_lo);
        end else begin
            if (o) begin
                div_end = 1'b1; div_by_zero = zero; div_hi = rh; div_lo = rl;
            end else begin
                mult_end = 1'b1; mult_hi = rh; mult_lo = rl;
            end
            if (o && zero) begin
                exp_q.push_back('{1, m_hi, m_lo});
            end else begin
                m_hi = rh;
                m_lo = rl;
                exp_q.push_back('{0, rh, rl});
            end
            @(negedge clk);
            clear_in();
            chk("busy_result", busy, 1);
        end
    endtask

    initial begin
        // Reset with a competing MTHI write.
        rst = 1'b0; hi_we = 1'b1; wdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {done, div_zero_exc, timeout_exc, mult_start, div_start}, 0);
        hi_we = 1'b0;
        rst = 1'b1;

        // MULT, end five cycles after start.
        do_op(1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h2);

        // MTHI/MTLO preload then divide by zero with div_end also high.
        wait_idle(40);
        hi_we = 1'b1; wdata = 32'hA;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hB;
        chk("mthi", hi, 32'hA);
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", lo, 32'hB);
        m_hi = 32'hA; m_lo = 32'hB;
        do_op(1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 32'h6);

        // Flush in D_WAIT, then MULT with spurious handshakes and a dropped req.
        do_op(1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h7, 32'h8);
        do_op(1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h5678);
        do_op(1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h9ABC, 32'hDEF0);

        // Flush in IDLE cancels req but keeps the MTHI write.
        wait_idle(40);
        req = 1'b1; flush = 1'b1; hi_we = 1'b1; wdata = 32'hCAFE_F00D;
        m_hi = 32'hCAFE_F00D;
        @(negedge clk);
        clear_in();
        chk("idle_flush_busy", busy, 0);
        chk("idle_flush_hi", hi, m_hi);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            do_op(1'($urandom), int'($urandom_range(5, 0)), ($urandom_range(3, 0) == 0),
                  ($urandom_range(4, 0) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, $urandom);
        end

`ifdef MULDIV_TIMEOUT_EN
        // MULT whose end never arrives.
        wait_idle(40);
        req = 1'b1; op = 1'b0;
        exp_q.push_back('{2, m_hi, m_lo});
        @(negedge clk);
        clear_in();
        wait_idle(TO + 10);
        chk("timeout_hi", hi, m_hi);
`else
        // Without the watchdog a long wait still completes normally.
        do_op(1'b0, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55, 32'hAA);
`endif

        // Reset in the middle of a DIV.
        wait_idle(40);
        req = 1'b1; op = 1'b1;
        @(negedge clk);
        clear_in();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        rst = 1'b1;
        m_hi = '0; m_lo = '0;

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the multiply and divide units and owner of the HI/LO architectural registers.
- Accepts one MULT/DIV request at a time from the main control FSM.
- Issues a one-cycle start pulse to the selected unit and waits for its end handshake.
- Commits the result to HI/LO, or raises a divide-by-zero exception.
- The control FSM stalls on busy and reads HI/LO for MFHI/MFLO; MTHI/MTLO writes also come through here.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in a WAIT state before watchdog abort (only with MULDIV_TIMEOUT_EN); minimum 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
req  in  1  operation request; sampled only in IDLE
op  in  1  0=MULT, 1=DIV; captured with req
flush  in  1  abort current operation (exception/redirect)
hi_we  in  1  MTHI write; accepted only in IDLE
lo_we  in  1  MTLO write; accepted only in IDLE
wdata  in  32  MTHI/MTLO data
mult_start  out  1  start pulse to multiplier
mult_end  in  1  multiplier done
mult_hi  in  32  multiplier high word
mult_lo  in  32  multiplier low word
div_start  out  1  start pulse to divider
div_end  in  1  divider done
div_hi  in  32  remainder
div_lo  in  32  quotient
div_by_zero  in  1  divider zero-divisor flag
hi  out  32  HI register
lo  out  32  LO register
busy  out  1  1 in every state except IDLE
done  out  1  one-cycle pulse, result committed
div_zero_exc  out  1  one-cycle pulse, divide by zero
timeout_exc  out  1  one-cycle pulse, watchdog abort

Behaviour:
Reset (rst=0 at a clock edge):
- State goes to IDLE.
- hi, lo, mult_start, div_start, done, div_zero_exc, timeout_exc all 0.
- Reset dominates every other input, mid-operation included.

States: IDLE, M_START, M_WAIT, D_START, D_WAIT, DONE, EXC.
- IDLE: if req=1 and flush=0, go to M_START (op=0) or D_START (op=1).
  - hi_we/lo_we load wdata into hi/lo at this edge.
  - If req and hi_we/lo_we arrive together, the write happens and the request is also accepted.
- M_START: mult_start=1 for exactly this cycle; go to M_WAIT. mult_end is ignored here.
- M_WAIT: on mult_end=1, hi<=mult_hi and lo<=mult_lo at that edge; go to DONE.
- D_START: div_start=1 for exactly this cycle; go to D_WAIT.
- D_WAIT:
  - div_by_zero=1 has priority over div_end: hi/lo unchanged; go to EXC with the zero cause.
  - Otherwise, on div_end=1: hi<=div_hi, lo<=div_lo; go to DONE.
- DONE: done=1 for this cycle; go to IDLE. req is ignored in DONE.
- EXC: the cause pulse (div_zero_exc or timeout_exc) =1 for this cycle; go to IDLE.

Latency: request in cycle 0, start in cycle 1, end sampled in cycle N; new hi/lo and done=1 are both visible in cycle N+1. The earliest next request is accepted in cycle N+2.

Boundary rules:
- An end or div_by_zero from the non-selected unit is ignored.
- flush=1 in any non-IDLE state: go to IDLE next edge, no HI/LO write, no done/exc pulse, start outputs 0.
- flush in IDLE: cancels any req in the same cycle; hi_we/lo_we are still honoured.
- A second req while busy is dropped; the requester must hold req until it sees busy=0.
- hi_we/lo_we outside IDLE are ignored.

Optional Feature:
MULDIV_TIMEOUT_EN:
- Defined: a cycle counter clears on entry to M_WAIT/D_WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES-1 with no end/div_by_zero, go to EXC with timeout_exc, hi/lo unchanged. An end arriving in that same cycle wins over the timeout.
- Undefined: WAIT states wait indefinitely; timeout_exc is tied to 0.

Decomposition:
- Package muldiv_pkg: state encoding (7 states), OP_MULT=0 and OP_DIV=1, default TIMEOUT_CYCLES.
- Sub-module muldiv_watchdog (counter with clear/enable/expired), instantiated only under MULDIV_TIMEOUT_EN.

Test Plan:
1. Reset: rst=0 for 2 cycles with hi_we=1, wdata=32'hFFFF_FFFF -> hi=lo=0, busy=0, no pulses.
2. MULT: req, op=0; mult_end 5 cycles after mult_start with mult_hi=32'h1, mult_lo=32'h2 -> mult_start high exactly 1 cycle; done pulse and hi=1, lo=2 in the same cycle; busy from cycle 1 to that cycle.
3. DIV by zero: req, op=1; div_by_zero=1 and div_end=1 together in D_WAIT, with hi/lo preloaded to 32'hA/32'hB via MTHI/MTLO -> div_zero_exc single pulse, no done, hi=32'hA, lo=32'hB.
4. flush in D_WAIT, then a late div_end -> IDLE next cycle, no done, hi/lo unchanged; the late div_end is ignored.
5. Spurious handshakes: mult_end during a DIV; req during M_WAIT -> both ignored; one done only; the second req is not serviced.
6. Watchdog (MULDIV_TIMEOUT_EN, TIMEOUT_CYCLES=8): MULT, mult_end never asserted -> timeout_exc pulse, then IDLE; hi/lo unchanged.
